// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle WIDTH-bit ALU with START/BUSY/DONE handshake
// Shift-add multiply and bit-serial shifts; outputs change only on the DONE edge.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic             ZERO,
  output logic             CARRY
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  localparam logic [WIDTH-1:0] W_LIM   = WIDTH'(WIDTH);
  localparam logic [CNTW-1:0]  CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0]  CNT_MUL = CNTW'(WIDTH);

  logic [0:0]       state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, w_q, hi_q;
  logic             shift_en;
  logic [CNTW-1:0]  cnt_q;

  logic [WIDTH:0]   mul_sum, add_sum;
  logic [WIDTH-1:0] w_next, hi_next, fin_lo, fin_hi;
  logic             fin_carry;

  assign BUSY = (state == S_RUN);

  // w_q holds the multiplier (MUL) or the working shift value (SLL/SRA)
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (w_q[0] ? {1'b0, a_q} : '0);
    add_sum   = {1'b0, a_q} + {1'b0, b_q};
    w_next    = w_q;
    hi_next   = hi_q;
    fin_hi    = '0;
    fin_carry = 1'b0;
    case (op_q)
      OP_MUL: begin
        hi_next = mul_sum[WIDTH:1];
        w_next  = {mul_sum[0], w_q[WIDTH-1:1]};
      end
      OP_SLL:  if (shift_en) w_next = {w_q[WIDTH-2:0], 1'b0};
      OP_SRA:  if (shift_en) w_next = {w_q[WIDTH-1], w_q[WIDTH-1:1]};
      default: ;
    endcase
    case (op_q)
      OP_FWD: fin_lo = b_q;
      OP_ADD: begin
        fin_lo    = add_sum[WIDTH-1:0];
        fin_carry = add_sum[WIDTH];
      end
      OP_AND: fin_lo = a_q & b_q;
      OP_OR:  fin_lo = a_q | b_q;
      OP_SUB: begin
        fin_lo    = a_q - b_q;
        fin_carry = (a_q < b_q);
      end
      OP_MUL: begin
        fin_lo = w_next;
        fin_hi = hi_next;
      end
      default: fin_lo = w_next;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      DONE      <= 1'b0;
      RESULT    <= '0;
      RESULT_HI <= '0;
      ZERO      <= 1'b1;
      CARRY     <= 1'b0;
      op_q      <= OP_FWD;
      a_q       <= '0;
      b_q       <= '0;
      w_q       <= '0;
      hi_q      <= '0;
      shift_en  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            state    <= S_RUN;
            op_q     <= SELECT;
            a_q      <= DATA1;
            b_q      <= DATA2;
            hi_q     <= '0;
            w_q      <= DATA1;
            shift_en <= 1'b0;
            cnt_q    <= CNT_ONE;
            case (SELECT)
              OP_MUL: begin
                w_q   <= DATA2;
                cnt_q <= CNT_MUL;
              end
              OP_SLL, OP_SRA: begin
                // out-of-range amounts resolve to the saturated value in one cycle
                if (DATA2 >= W_LIM) begin
                  w_q <= (SELECT == OP_SRA) ? {WIDTH{DATA1[WIDTH-1]}} : '0;
                end else if (DATA2 != '0) begin
                  shift_en <= 1'b1;
                  cnt_q    <= DATA2[CNTW-1:0];
                end
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - CNT_ONE;
          w_q   <= w_next;
          hi_q  <= hi_next;
          if (cnt_q == CNT_ONE) begin
            state     <= S_IDLE;
            DONE      <= 1'b1;
            RESULT    <= fin_lo;
            RESULT_HI <= fin_hi;
            ZERO      <= (fin_lo == '0);
            CARRY     <= fin_carry;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
